cam_frame_grab_ctrl: RTL and testbench

- Sequences capture of the CMOS pixel stream (16-bit RGB565 write strobe plus frame_valid) into a double-buffered on-chip frame RAM for the MobileNet engine.
- Crops a fixed WIN_W x WIN_H window and writes it linearly into one of two banks.
- Hands completed banks to the consumer through a ready/release handshake.
- Sits between CMOS_Capture's output (already in the clk domain) and the CNN input buffer.

---
 rtl/cam_pkg.sv | 23 ++
 rtl/cam_frame_grab_ctrl_crop_addr_gen.sv | 77 +++++++
 rtl/cam_frame_grab_ctrl.sv | 159 +++++++++++++++
 tb/tb_cam_frame_grab_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types for the camera frame-grab controller: FSM states, pixel type and
// window-size helpers.
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SYNC,
    CAPTURE,
    END
  } state_t;

  typedef logic [15:0] rgb565_t;

  localparam int unsigned WIN_W_DEF = 128;
  localparam int unsigned WIN_H_DEF = 128;
  localparam int unsigned WIN_PIX   = WIN_W_DEF * WIN_H_DEF;

  function automatic int unsigned win_pix(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/cam_frame_grab_ctrl_crop_addr_gen.sv
// Source x/y position tracking, crop-window test and linear offset counter for
// the pixels that land inside the capture window.
module crop_addr_gen
  import cam_pkg::*;
#(
  parameter int unsigned SRC_W = 1024,
  parameter int unsigned SRC_H = 768,
  parameter int unsigned X0    = 448,
  parameter int unsigned Y0    = 320,
  parameter int unsigned WIN_W = 128,
  parameter int unsigned WIN_H = 128,
  parameter int unsigned AW    = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          pix_en,
  output logic          in_win,
  output logic [AW-1:0] offset
);

  localparam int unsigned XW = $clog2(SRC_W);
  localparam int unsigned YW = $clog2(SRC_H + 1);
  localparam logic [XW-1:0] X_LAST   = XW'(SRC_W - 1);
  localparam logic [YW-1:0] Y_END    = YW'(SRC_H);
  localparam logic [XW:0]   X_LO     = (XW+1)'(X0);
  localparam logic [XW:0]   X_HI     = (XW+1)'(X0 + WIN_W);
  localparam logic [YW:0]   Y_LO     = (YW+1)'(Y0);
  localparam logic [YW:0]   Y_HI     = (YW+1)'(Y0 + WIN_H);
  localparam logic [AW-1:0] OFF_FULL = AW'(win_pix(WIN_W, WIN_H));

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] off_q, off_d;
  logic          y_act;
  logic          x_hit;
  logic          y_hit;

  always_comb begin
    // Lines past the source height are dropped and y stays parked at SRC_H.
    y_act  = (y_q < Y_END);
    x_hit  = ({1'b0, x_q} >= X_LO) && ({1'b0, x_q} < X_HI);
    y_hit  = ({1'b0, y_q} >= Y_LO) && ({1'b0, y_q} < Y_HI);
    in_win = pix_en && y_act && x_hit && y_hit && (off_q != OFF_FULL);
    x_d    = x_q;
    y_d    = y_q;
    off_d  = off_q;
    if (clr) begin
      x_d   = '0;
      y_d   = '0;
      off_d = '0;
    end else if (pix_en && y_act) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
      if (in_win) off_d = off_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      off_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      off_q <= off_d;
    end
  end

  assign offset = off_q;

endmodule

// File: rtl/cam_frame_grab_ctrl.sv
// Capture sequencer: crops the CMOS pixel stream into a double-buffered frame RAM
// and hands completed banks to the CNN consumer via a ready/release handshake.
module cam_frame_grab_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned SRC_W = 1024,
  parameter int unsigned SRC_H = 768,
  parameter int unsigned X0    = 448,
  parameter int unsigned Y0    = 320,
  parameter int unsigned WIN_W = 128,
  parameter int unsigned WIN_H = 128,
  parameter int unsigned AW    = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cont_en,
  input  logic          pix_we,
  input  logic [15:0]   pix_data,
  input  logic          frame_valid,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [15:0]   ram_wdata,
  output logic          buf_ready,
  output logic          buf_sel,
  input  logic          buf_release,
  output logic          busy,
  output logic          frame_drop,
  output logic          err_short,
  output logic [7:0]    frame_cnt
);

  localparam logic [AW-1:0] OFF_FULL = AW'(win_pix(WIN_W, WIN_H));

  state_t        state_q, state_d;
  logic          fv_q, fv_d;
  logic          wr_bank_q, wr_bank_d;
  logic          buf_ready_q, buf_ready_d;
  logic          buf_sel_q, buf_sel_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          frame_drop_q, frame_drop_d;
  logic          err_short_q, err_short_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  rgb565_t       ram_wdata_q, ram_wdata_d;
  logic          busy_q, busy_d;

  logic          pix_en;
  logic          clr;
  logic          in_win;
  logic [AW-1:0] offset;
  logic          ready_after;

  assign pix_en = pix_we && frame_valid && (state_q == CAPTURE);
  assign clr    = (state_q == SYNC);

  crop_addr_gen #(
    .SRC_W(SRC_W),
    .SRC_H(SRC_H),
    .X0   (X0),
    .Y0   (Y0),
    .WIN_W(WIN_W),
    .WIN_H(WIN_H),
    .AW   (AW)
  ) u_crop (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .pix_en(pix_en),
    .in_win(in_win),
    .offset(offset)
  );

  always_comb begin
    state_d      = state_q;
    fv_d         = frame_valid;
    wr_bank_d    = wr_bank_q;
    buf_sel_d    = buf_sel_q;
    frame_cnt_d  = frame_cnt_q;
    frame_drop_d = 1'b0;
    err_short_d  = 1'b0;
    ram_we_d     = in_win;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    // A release is honoured before the END decision, so a coincident publish
    // sees the consumer's bank as already returned.
    ready_after  = buf_ready_q && !buf_release;
    buf_ready_d  = ready_after;

    if (in_win) begin
      ram_addr_d  = wr_bank_q ? (OFF_FULL + offset) : offset;
      ram_wdata_d = pix_data;
    end

    unique case (state_q)
      IDLE:    if (start) state_d = ARM;
      ARM:     if (!frame_valid) state_d = SYNC;
      SYNC:    if (frame_valid && !fv_q) state_d = CAPTURE;
      CAPTURE: if (!frame_valid && fv_q) state_d = END;
      END: begin
        state_d = cont_en ? ARM : IDLE;
        if (offset != OFF_FULL) begin
          err_short_d = 1'b1;
        end else if (!ready_after) begin
          buf_ready_d = 1'b1;
          buf_sel_d   = wr_bank_q;
          wr_bank_d   = !wr_bank_q;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
          frame_drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fv_q         <= 1'b0;
      wr_bank_q    <= 1'b0;
      buf_ready_q  <= 1'b0;
      buf_sel_q    <= 1'b0;
      frame_cnt_q  <= '0;
      frame_drop_q <= 1'b0;
      err_short_q  <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fv_q         <= fv_d;
      wr_bank_q    <= wr_bank_d;
      buf_ready_q  <= buf_ready_d;
      buf_sel_q    <= buf_sel_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_drop_q <= frame_drop_d;
      err_short_q  <= err_short_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign buf_ready  = buf_ready_q;
  assign buf_sel    = buf_sel_q;
  assign busy       = busy_q;
  assign frame_drop = frame_drop_q;
  assign err_short  = err_short_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_cam_frame_grab_ctrl.sv
// Scoreboard bench for cam_frame_grab_ctrl on an 8x6 source with a 4x3 window at (2,1).
module tb_cam_frame_grab_ctrl;

  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          cont_en;
  logic          pix_we;
  logic [15:0]   pix_data;
  logic          frame_valid;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic          buf_ready;
  logic          buf_sel;
  logic          buf_release;
  logic          busy;
  logic          frame_drop;
  logic          err_short;
  logic [7:0]    frame_cnt;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            cyc;
  } wr_t;

  wr_t q[$];
  wr_t mon_e;
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  nwr = 0;
  int  ndrop = 0;
  int  nerr = 0;

  cam_frame_grab_ctrl #(
    .SRC_W(8),
    .SRC_H(6),
    .X0   (2),
    .Y0   (1),
    .WIN_W(4),
    .WIN_H(3),
    .AW   (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cont_en    (cont_en),
    .pix_we     (pix_we),
    .pix_data   (pix_data),
    .frame_valid(frame_valid),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .buf_ready  (buf_ready),
    .buf_sel    (buf_sel),
    .buf_release(buf_release),
    .busy       (busy),
    .frame_drop (frame_drop),
    .err_short  (err_short),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_window(input int k);
    int x, y;
    x = k % 8;
    y = k / 8;
    return (y >= 1) && (y < 4) && (x >= 2) && (x < 6);
  endfunction

  // Pops one expected write per ram_we and checks address, data and cycle.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_drop) ndrop++;
        if (err_short) nerr++;
        if (ram_we) begin
          nwr++;
          vectors++;
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write cyc=%0d addr=%0d data=%h", cyc, ram_addr, ram_wdata);
          end else begin
            mon_e = q.pop_front();
            if (ram_addr !== mon_e.addr || ram_wdata !== mon_e.data || cyc != mon_e.cyc) begin
              miscompares++;
              $display("FAIL write got addr=%0d data=%h cyc=%0d exp addr=%0d data=%h cyc=%0d",
                       ram_addr, ram_wdata, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
            end
          end
        end
      end
    end
  endtask

  task automatic send_frame(input int n, input logic [AW-1:0] base, input bit rel_end);
    int off;
    wr_t e;
    off = 0;
    pix_we = 1'b0;
    frame_valid = 1'b0;
    repeat (3) tick();
    frame_valid = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < n; k++) begin
      pix_we   = 1'b1;
      pix_data = 16'($urandom);
      if (in_window(k)) begin
        e.addr = base + AW'(off);
        e.data = pix_data;
        e.cyc  = cyc + 1;
        q.push_back(e);
        off++;
      end
      tick();
      if (k % 5 == 4) begin
        pix_we = 1'b0;
        tick();
      end
    end
    pix_we = 1'b0;
    frame_valid = 1'b0;
    tick();
    buf_release = rel_end;
    tick();
    buf_release = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic release_buf();
    buf_release = 1'b1;
    tick();
    buf_release = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    start = 1'b0; cont_en = 1'b0; pix_we = 1'b0; frame_valid = 1'b0; buf_release = 1'b0;
    rst_n = 1'b0;
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    vectors++;
    if ({ram_we, ram_addr, ram_wdata, buf_ready, buf_sel, busy, frame_drop, err_short, frame_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got we=%b addr=%0d wd=%h rdy=%b sel=%b busy=%b drop=%b err=%b cnt=%0d exp all 0",
               ram_we, ram_addr, ram_wdata, buf_ready, buf_sel, busy, frame_drop, err_short, frame_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    int w0;
    w0 = nwr;
    pulse_start();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b exp=1", busy); end
    send_frame(48, 5'd0, 1'b0);
    vectors++;
    if (nwr - w0 != 12 || q.size() != 0) begin
      miscompares++;
      $display("FAIL single_write_count got=%0d pending=%0d exp 12 and 0", nwr - w0, q.size());
    end
    vectors++;
    if ({buf_ready, buf_sel, frame_cnt, busy} !== {1'b1, 1'b0, 8'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_publish got rdy=%b sel=%b cnt=%0d busy=%b exp 1 0 1 0", buf_ready, buf_sel, frame_cnt, busy);
    end
    release_buf();
    vectors++;
    if (buf_ready !== 1'b0) begin miscompares++; $display("FAIL single_release got=%b exp=0", buf_ready); end
  endtask

  task automatic test_cont_release();
    logic [AW-1:0] bases[3];
    bases[0] = 5'd0; bases[1] = 5'd12; bases[2] = 5'd0;
    do_reset();
    cont_en = 1'b1;
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      if (f == 2) cont_en = 1'b0;
      send_frame(48, bases[f], 1'b0);
      vectors++;
      if ({buf_ready, buf_sel} !== {1'b1, 1'(f % 2)}) begin
        miscompares++;
        $display("FAIL cont_sel frame=%0d got rdy=%b sel=%b exp rdy=1 sel=%0d", f, buf_ready, buf_sel, f % 2);
      end
      if (f < 2) release_buf();
    end
    vectors++;
    if (frame_cnt !== 8'd3 || busy !== 1'b0 || q.size() != 0) begin
      miscompares++;
      $display("FAIL cont_cnt got cnt=%0d busy=%b pending=%0d exp 3 0 0", frame_cnt, busy, q.size());
    end
  endtask

  task automatic test_no_release();
    do_reset();
    cont_en = 1'b1;
    pulse_start();
    send_frame(48, 5'd0, 1'b0);
    send_frame(48, 5'd12, 1'b0);
    vectors++;
    if (ndrop !== 1 || {buf_ready, buf_sel, frame_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      miscompares++;
      $display("FAIL drop_first got drops=%0d rdy=%b sel=%b cnt=%0d exp 1 1 0 1", ndrop, buf_ready, buf_sel, frame_cnt);
    end
    cont_en = 1'b0;
    send_frame(48, 5'd12, 1'b0);
    vectors++;
    if (ndrop !== 2 || buf_sel !== 1'b0 || frame_cnt !== 8'd1 || q.size() != 0) begin
      miscompares++;
      $display("FAIL drop_second got drops=%0d sel=%b cnt=%0d pending=%0d exp 2 0 1 0", ndrop, buf_sel, frame_cnt, q.size());
    end
  endtask

  task automatic test_short_frame();
    int w0;
    do_reset();
    w0 = nwr;
    cont_en = 1'b1;
    pulse_start();
    send_frame(20, 5'd0, 1'b0);
    vectors++;
    if (nerr !== 1 || buf_ready !== 1'b0 || frame_cnt !== 8'd0 || nwr - w0 != 6) begin
      miscompares++;
      $display("FAIL short_err got errs=%0d rdy=%b cnt=%0d writes=%0d exp 1 0 0 6", nerr, buf_ready, frame_cnt, nwr - w0);
    end
    cont_en = 1'b0;
    send_frame(48, 5'd0, 1'b0);
    vectors++;
    if (nerr !== 1 || {buf_ready, buf_sel, frame_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      miscompares++;
      $display("FAIL short_recover got errs=%0d rdy=%b sel=%b cnt=%0d exp 1 1 0 1", nerr, buf_ready, buf_sel, frame_cnt);
    end
  endtask

  task automatic test_release_at_end();
    int d0;
    d0 = ndrop;
    pulse_start();
    send_frame(48, 5'd12, 1'b1);
    vectors++;
    if ({buf_ready, buf_sel, frame_cnt} !== {1'b1, 1'b1, 8'd2} || ndrop != d0) begin
      miscompares++;
      $display("FAIL release_at_end got rdy=%b sel=%b cnt=%0d drops=%0d exp 1 1 2 %0d", buf_ready, buf_sel, frame_cnt, ndrop, d0);
    end
  endtask

  task automatic test_start_mid_frame();
    wr_t e;
    int off;
    do_reset();
    frame_valid = 1'b1;
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      pix_we = 1'b1;
      pix_data = 16'($urandom);
      tick();
    end
    pix_we = 1'b0;
    vectors++;
    if (busy !== 1'b1 || nwr != 0) begin
      miscompares++;
      $display("FAIL mid_frame_armed got busy=%b writes=%0d exp 1 0", busy, nwr);
    end
    frame_valid = 1'b0;
    repeat (3) tick();
    frame_valid = 1'b1;
    repeat (2) tick();
    off = 0;
    for (int k = 0; k < 13; k++) begin
      pix_we = 1'b1;
      pix_data = 16'($urandom);
      if (in_window(k)) begin
        e.addr = AW'(off); e.data = pix_data; e.cyc = cyc + 1;
        q.push_back(e);
        off++;
      end
      tick();
    end
    pix_we = 1'b0;
    vectors++;
    if (ram_we !== 1'b1) begin miscompares++; $display("FAIL mid_capture_we got=%b exp=1", ram_we); end
    q.delete();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ram_we, busy, ram_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_capture got we=%b busy=%b addr=%0d exp 0 0 0", ram_we, busy, ram_addr);
    end
    frame_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_frame(48, 5'd0, 1'b0);
    vectors++;
    if ({buf_ready, buf_sel, frame_cnt} !== {1'b1, 1'b0, 8'd1} || q.size() != 0) begin
      miscompares++;
      $display("FAIL after_reset_frame got rdy=%b sel=%b cnt=%0d pending=%0d exp 1 0 1 0", buf_ready, buf_sel, frame_cnt, q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cont_en = 1'b0;
    pix_we = 1'b0;
    pix_data = '0;
    frame_valid = 1'b0;
    buf_release = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_frame();
    test_cont_release();
    ndrop = 0;
    test_no_release();
    nerr = 0;
    test_short_frame();
    test_release_at_end();
    nwr = 0;
    test_start_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
